// File: rtl/pdm_cic_pkg.sv
// Shared helpers for the PDM -> CIC serializers: width derivation and
// bit-vector utilities used on the channel-pending mask.
package pdm_cic_pkg;

  localparam int MAX_MICS = 64;

  typedef logic [MAX_MICS-1:0] mic_vec_t;

  function automatic int cic_bits(input int bytes);
    return bytes * 8;
  endfunction

  function automatic int id_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic int lowest_set(input mic_vec_t v);
    int idx;
    idx = 0;
    for (int i = MAX_MICS - 1; i >= 0; i--)
      if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic logic is_onehot(input mic_vec_t v);
    return (v != '0) && ((v & (v - mic_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/skidbuf.sv
// One-deep output register plus skid register; s_ready is registered so the
// upstream ready path never sees downstream combinational logic.
module skidbuf #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data
);

  logic            skid_valid;
  logic [BITS-1:0] skid_data;
  logic            s_hs;

  assign s_hs = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
    end else if (m_ready || !m_valid) begin
      // s_ready was low whenever skid_valid is set, so no beat is lost here
      if (skid_valid) begin
        m_valid    <= 1'b1;
        m_data     <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        m_valid <= s_hs;
        if (s_hs) m_data <= s_data;
      end
      s_ready <= 1'b1;
    end else if (s_hs) begin
      skid_valid <= 1'b1;
      skid_data  <= s_data;
      s_ready    <= 1'b0;
    end else begin
      s_ready <= !skid_valid;
    end
  end

endmodule

// File: rtl/pdm_cic_masked_serializer.sv
// PDM word -> per-enabled-channel CIC sample stream with run-time channel mask.
// Define PDM_CIC_TUSER_EN to drive m_axis_tuser with the channel index.
module pdm_cic_masked_serializer
  import pdm_cic_pkg::*;
#(
  parameter int NUM_MICS       = 8,
  parameter int CIC_BYTES      = 1,
  parameter int CIC_BITS       = cic_bits(CIC_BYTES),
  parameter int OUT_ZERO_VALUE = -1,
  parameter int OUT_ONE_VALUE  = 1,
  parameter int ID_BITS        = id_bits(NUM_MICS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_MICS-1:0] ch_mask,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [NUM_MICS-1:0] s_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [CIC_BITS-1:0] m_axis_tdata,
  output logic [ID_BITS-1:0]  m_axis_tuser,
  output logic                m_axis_tlast,
  output logic [15:0]         empty_words
);

  localparam logic [CIC_BITS-1:0] ONE_V  = CIC_BITS'(OUT_ONE_VALUE);
  localparam logic [CIC_BITS-1:0] ZERO_V = CIC_BITS'(OUT_ZERO_VALUE);

  logic                sk_valid;
  logic                sk_ready;
  logic [NUM_MICS-1:0] sk_data;

  skidbuf #(.BITS(NUM_MICS)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .s_data  (s_axis_tdata),
    .m_valid (sk_valid),
    .m_ready (sk_ready),
    .m_data  (sk_data)
  );

  logic [NUM_MICS-1:0] word;
  logic [NUM_MICS-1:0] pend;
  logic [NUM_MICS-1:0] src_word;
  logic [NUM_MICS-1:0] src_mask;
  logic [NUM_MICS-1:0] low;
  logic                busy;
  logic                last_pend;
  logic                advance;
  logic                load;
  logic                emit;
  logic                bit_v;
  logic                is_last;

  assign busy      = |pend;
  assign last_pend = is_onehot(mic_vec_t'(pend));
  assign advance   = m_axis_tready || !m_axis_tvalid;
  // A new word loads while the previous word's final channel goes out
  assign load      = advance && sk_valid && (!busy || last_pend);
  assign emit      = advance && (busy || (sk_valid && (|ch_mask)));
  assign sk_ready  = load;

  // When idle the first channel is taken straight from the incoming word
  assign src_word = busy ? word : sk_data;
  assign src_mask = busy ? pend : ch_mask;
  assign low      = src_mask & (~src_mask + NUM_MICS'(1));
  assign bit_v    = |(src_word & low);
  assign is_last  = (src_mask & ~low) == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      word          <= '0;
      pend          <= '0;
      empty_words   <= '0;
    end else if (advance) begin
      m_axis_tvalid <= emit;
      if (emit) begin
        m_axis_tdata <= bit_v ? ONE_V : ZERO_V;
        m_axis_tlast <= is_last;
      end
      if (load) begin
        word <= sk_data;
        pend <= busy ? ch_mask : (ch_mask & ~low);
        if (ch_mask == '0 && empty_words != 16'hFFFF)
          empty_words <= empty_words + 16'd1;
      end else if (emit) begin
        pend <= pend & ~low;
      end
    end
  end

`ifdef PDM_CIC_TUSER_EN
  logic [ID_BITS-1:0] tuser_q;

  always_ff @(posedge clk) begin
    if (rst)
      tuser_q <= '0;
    else if (emit)
      tuser_q <= ID_BITS'(lowest_set(mic_vec_t'(src_mask)));
  end

  assign m_axis_tuser = tuser_q;
`else
  assign m_axis_tuser = '0;
`endif

endmodule

// File: tb/tb_pdm_cic_masked_serializer.sv
// Randomized self-checking bench: a queue of expected beats is built from each
// accepted word and its mask, then compared against every output handshake.
module tb_pdm_cic_masked_serializer;

`ifdef PDM_CIC_TUSER_EN
  localparam bit TUSER_EN = 1'b1;
`else
  localparam bit TUSER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ch_mask;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] empty_words;

  pdm_cic_masked_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .ch_mask       (ch_mask),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .empty_words   (empty_words)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] u;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int    errs = 0;
  int    checks = 0;
  int    exp_empty = 0;
  int    out_beats = 0;
  int    rdy_pct = 100;
  bit    auto_push = 1'b1;
  bit    prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic [2:0] prev_u;
  logic       prev_l;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: enabled channels ascending, +1/-1 per bit, last = highest enabled
  function automatic void push_word(input logic [7:0] d, input logic [7:0] m);
    beat_t b;
    if (m == 8'h00) exp_empty++;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        b.d = d[i] ? 8'h01 : 8'hFF;
        b.u = TUSER_EN ? 3'(i) : 3'd0;
        b.l = ((m >> (i + 1)) == 8'h00);
        exp_q.push_back(b);
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
  end

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (auto_push && s_axis_tvalid && s_axis_tready)
        push_word(s_axis_tdata, ch_mask);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", 32'(m_axis_tdata), 32'(prev_d));
        chk("stall_user", 32'(m_axis_tuser), 32'(prev_u));
        chk("stall_last", 32'(m_axis_tlast), 32'(prev_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
          chk("tdata", 32'(m_axis_tdata), 32'(b.d));
          chk("tuser", 32'(m_axis_tuser), 32'(b.u));
          chk("tlast", 32'(m_axis_tlast), 32'(b.l));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_u = m_axis_tuser;
      prev_l = m_axis_tlast;
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 500);
    if (n >= 500) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int cnt);
    int base;
    int n;
    base = out_beats;
    n = 0;
    while (out_beats < base + cnt && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) chk("beat_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h00;
    ch_mask = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_empty", 32'(empty_words), 32'd0);
    chk("rst_sready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("sready_after_rst", 32'(s_axis_tready), 32'd1);
    @(posedge clk);
    #1;

    // Full mask, known word, first-beat latency
    send(8'hA5);
    @(negedge clk);
    chk("latency_t1", 32'(m_axis_tvalid), 32'd0);
    @(negedge clk);
    chk("latency_t2", 32'(m_axis_tvalid), 32'd1);
    drain();

    ch_mask = 8'h24;
    send(8'hFF);
    drain();

    // Zero-mask words are consumed silently and counted
    ch_mask = 8'h00;
    repeat (3) send(8'($urandom));
    drain();
    ch_mask = 8'h01;
    send(8'($urandom));
    drain();
    chk("empty_words_3", 32'(empty_words), 32'd3);

    // Continuous input under random backpressure
    rdy_pct = 50;
    ch_mask = 8'hFF;
    repeat (40) send(8'($urandom));
    drain();

    for (int p = 0; p < 5; p++) begin
      ch_mask = (p == 0) ? 8'h00 : 8'($urandom);
      repeat (12) send(8'($urandom));
      drain();
    end
    chk("empty_words_model", 32'(empty_words), 32'(exp_empty));

    // Mask change mid-word only affects the next word
    rdy_pct = 100;
    ch_mask = 8'hFF;
    drain();
    auto_push = 1'b0;
    begin
      logic [7:0] wa;
      logic [7:0] wb;
      wa = 8'($urandom);
      wb = 8'($urandom);
      push_word(wa, 8'hFF);
      push_word(wb, 8'h01);
      fork
        begin
          send(wa);
          send(wb);
        end
        begin
          wait_beats(3);
          #1;
          ch_mask = 8'h01;
        end
      join
    end
    drain();
    auto_push = 1'b1;

    // Reset mid-word drops pending beats and the buffered word
    ch_mask = 8'hFF;
    send(8'h3C);
    send(8'hC3);
    wait_beats(4);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("midrst_sready", 32'(s_axis_tready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ch_mask = 8'h24;
    send(8'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_first_user", 32'(m_axis_tuser), TUSER_EN ? 32'd2 : 32'd0);
    drain();
    chk("post_rst_empty", 32'(empty_words), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pdm_cic_masked_serializer.md
# pdm_cic_masked_serializer

Channel-masked successor to the fixed PDM→CIC serializer. Accepts one NUM_MICS-bit PDM sample word per AXI-Stream beat and emits one CIC_BITS-wide signed sample per *enabled* microphone, in ascending channel order, with the channel index on tuser and tlast on the last enabled channel. It sits between the PDM capture block and the Xilinx CIC compiler and adds a run-time channel-enable mask, so unused microphones cost no CIC bandwidth.

## Interface
- NUM_MICS, 8: microphones per input word (≥2).
- CIC_BYTES, 1: output sample bytes.
- CIC_BITS, CIC_BYTES*8: output tdata width.
- OUT_ZERO_VALUE, -1: sample value for PDM bit 0.
- OUT_ONE_VALUE, 1: sample value for PDM bit 1.
- ID_BITS, $clog2(NUM_MICS): tuser width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ch_mask  in  NUM_MICS  channel enable; sampled only at word load.
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
- s_axis_tdata  in  NUM_MICS  PDM bits, bit i = mic i.
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
- m_axis_tdata  out  CIC_BITS  mapped sample, sign-extended/truncated to CIC_BITS.
- m_axis_tuser  out  ID_BITS  channel index of current beat.
- m_axis_tlast  out  1  last enabled channel of the word.
- empty_words  out  16  count of words loaded with all-zero mask; saturates at 0xFFFF.

## Operation
- Input passes through a 1-deep-plus-skid buffer; s_axis_tready is registered.
- State: hold register `word`, pending-channel register `pend` (NUM_MICS bits). pend==0 ⇒ idle.
- advance = m_axis_tready || !m_axis_tvalid.
- Emit: on advance with pend≠0, ch = lowest set bit of pend; m_axis_tdata ← word[ch] ? OUT_ONE_VALUE : OUT_ZERO_VALUE; tuser ← ch; tlast ← (pend is one-hot); tvalid ← 1; clear bit ch.
- Load: on advance when (pend==0 or pend one-hot) and skid valid: word ← skid data, pend ← ch_mask, skid pops. Load coincides with the last emit of the previous word → no bubble.
- advance with pend==0 and nothing loaded: tvalid ← 0.
- Zero mask at load: word consumed, no beats, empty_words increments (saturating); next word may load the following cycle.
- ch_mask changes mid-word have no effect until next load.
- tlast always marks the highest enabled channel; every loaded word with ≥1 enabled channel produces exactly popcount(mask) beats.

## Timing
- Reset: m_axis_tvalid 0, tdata 0, tuser 0, tlast 0, pend 0, empty_words 0, s_axis_tready 0 while rst high, 1 the cycle after release.
- Latency: input beat accepted at cycle t → first output valid at t+2 (skid + load/emit register) when output idle.
- Throughput: one output beat per cycle under continuous tready; input accepted once per popcount(mask) cycles.
- Backpressure: m_axis_tdata/tuser/tlast stable while tvalid && !tready.
- Reset mid-word: pending beats discarded, no tlast emitted, skid contents dropped.

## Configuration
- PDM_CIC_TUSER_EN defined: m_axis_tuser driven as above.
- Not defined: m_axis_tuser port remains, tied to 0; tuser register and index mux not synthesized. All other behaviour unchanged.

## Structure
- Shared package pdm_cic_pkg: CIC_BITS derivation, ID width function, lowest-set-bit function, one-hot test function.
- Sub-module: existing skidbuf (BITS=NUM_MICS) on the input.

## Test plan
- NUM_MICS=8, mask 0xFF, word 0xA5, tready=1 → 8 beats, tuser 0..7, tdata 1,-1,1,-1,-1,1,-1,1, tlast only on tuser 7.
- Mask 0x24, word 0xFF → 2 beats: tuser 2 (tdata 1), tuser 5 (tdata 1, tlast=1).
- Mask 0x00 for three words, then 0x01 → empty_words=3, single beat tuser 0 tlast=1.
- Continuous input, mask 0xFF, random tready 50% → no loss, no duplicate, data stable under stall, tlast every 8th beat.
- Mask change 0xFF→0x01 during beat 3 of a word → current word finishes all 8 beats, next word 1 beat.
- rst asserted after beat 4 of a word → tvalid 0 next cycle, no tlast, next word after release restarts at lowest enabled channel.
